classifier_result_tx: RTL and testbench
=======================================

Name: classifier_result_tx

Overview:
- Transmit end of the classifier datapath: captures one parallel classification result (class id plus per-class scores) and serialises it into a framed AXI-Stream packet toward the DMA/host.
- Complements the stream-input wrapper, which consumes AXI-Stream feature data.
- Frame = 1 header beat + NUM_CLASSES score beats (+ optional checksum beat), with tlast on the final beat and full backpressure support.

Parameters:
- DATA_WIDTH, 32, AXI-Stream data width; the header layout requires exactly 32.
- KEEP_WIDTH, 4, tkeep width = DATA_WIDTH/8.
- NUM_CLASSES, 10, number of score beats per frame; range 1..255.
- SCORE_WIDTH, 16, width of each signed score; must be ≤ DATA_WIDTH.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- res_valid  input  1  result available.
- res_ready  output  1  block can accept a result.
- res_class  input  8  winning class index; only the low 8 bits are used.
- res_scores  input  NUM_CLASSES*SCORE_WIDTH  packed signed scores, class 0 in the LSBs.
- m_axis_tdata  output  DATA_WIDTH  stream data.
- m_axis_tkeep  output  KEEP_WIDTH  byte enables; always all-ones while tvalid.
- m_axis_tvalid  output  1  beat valid.
- m_axis_tready  input  1  downstream ready.
- m_axis_tlast  output  1  final beat of frame.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; seq = 0.
  - m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, m_axis_tkeep = 0.
  - res_ready = 0 while rst is high, then 1.
- res_ready = 1 only in IDLE (registered-state decode, no combinational path from m_axis_tready).
- Result capture:
  - On res_valid && res_ready (cycle T): res_class and res_scores are latched into internal registers.
  - FSM moves to HDR; the header is presented with tvalid = 1 at T+1.
- States and transitions:
  - IDLE → HDR on result handshake.
  - HDR → SCORE on beat accept (tvalid && tready). seq increments (mod 256) on header accept.
  - SCORE: beat index idx runs 0..NUM_CLASSES-1.
  - SCORE → IDLE when beat idx = NUM_CLASSES-1 is accepted.
  - With CLASSIFIER_TX_CRC_EN defined: SCORE → CHK instead, then CHK → IDLE on accept.
- Header beat layout:
  - [31:24] = 8'hC1 (magic).
  - [23:16] = seq.
  - [15:8] = NUM_CLASSES.
  - [7:0] = latched class id.
- Score beat idx: score[idx] sign-extended to DATA_WIDTH.
- tlast = 1 only on the final beat of the frame. With NUM_CLASSES = 1, that is the single score beat.
- AXI rules:
  - Once tvalid is asserted, tdata/tkeep/tlast are held stable until accepted.
  - tvalid never drops without acceptance, except on reset.
  - Output registers update only on accept or on state entry.
- Throughput: one beat per cycle while tready = 1. One mandatory IDLE cycle between frames, so a frame costs NUM_CLASSES+2 cycles minimum.
- Input changes on res_* after capture have no effect on the frame in flight.
- Reset mid-frame: the frame is truncated immediately (tvalid → 0, no tlast), seq returns to 0, and the next frame starts clean. Downstream must treat a reset as a stream flush.
- seq wraps 255 → 0 with no special handling.

Optional Feature:
- Macro: CLASSIFIER_TX_CRC_EN.
- Defined:
  - A CHK beat is appended after the scores.
  - tdata = XOR of all prior beats' tdata in this frame (header included); accumulated on accept.
  - tlast moves from the final score beat to the CHK beat.
  - Frame length = NUM_CLASSES+2.
- Undefined: no CHK state, no accumulator; frame length = NUM_CLASSES+1.

Decomposition:
- Shared package classifier_pkg:
  - Header magic constant 8'hC1.
  - Header field bit positions.
  - FSM state typedef (IDLE, HDR, SCORE, CHK).
  - Default NUM_CLASSES/SCORE_WIDTH.
- One natural sub-module: axis_out_reg. It is the registered AXI-Stream output stage holding data/keep/last/valid with load-on-accept semantics.
- Score mux and FSM stay in the top module.

Test Plan:
- Single frame, tready tied 1, NUM_CLASSES=10, class=3, scores 0..9 → header 32'hC1000A03, then 10 beats 0..9; tlast only on beat 11; res_ready low for 11 cycles, then high.
- Negative score: score[0] = 16'hFFFE → beat 2 tdata = 32'hFFFFFFFE; tkeep = 4'hF on every beat.
- Random tready backpressure (≈50%) → tdata/tlast stable whenever tvalid && !tready; frame contents identical to the no-stall run; res_* toggling mid-frame ignored.
- 257 back-to-back frames → seq field 0x00..0xFF then 0x00; gap of exactly 1 idle cycle between frames with tready = 1.
- rst asserted during score beat 5 → tvalid = 0 in the same cycle; after release, the next frame's header seq = 0 and it is complete and correct.
- CLASSIFIER_TX_CRC_EN defined, scores all 1, class 0, seq 0 → CHK beat = 32'hC1000A00 ^ (XOR of ten 32'h1 beats = 0) = 32'hC1000A00, tlast on CHK only.

Source files
------------

// File: rtl/classifier_pkg.sv
// Shared constants, header layout and FSM state type for the classifier
// result transmitter.
package classifier_pkg;

  localparam int unsigned DEF_NUM_CLASSES = 10;
  localparam int unsigned DEF_SCORE_WIDTH = 16;

  localparam logic [7:0]  HDR_MAGIC     = 8'hC1;
  localparam int unsigned HDR_MAGIC_LSB = 24;
  localparam int unsigned HDR_SEQ_LSB   = 16;
  localparam int unsigned HDR_NCLS_LSB  = 8;
  localparam int unsigned HDR_CLASS_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    SCORE,
    CHK
  } tx_state_e;

  function automatic logic [31:0] pack_hdr(
    input logic [7:0] seq,
    input logic [7:0] ncls,
    input logic [7:0] cls
  );
    logic [31:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 8] = HDR_MAGIC;
    h[HDR_SEQ_LSB   +: 8] = seq;
    h[HDR_NCLS_LSB  +: 8] = ncls;
    h[HDR_CLASS_LSB +: 8] = cls;
    return h;
  endfunction

endpackage

// File: rtl/classifier_result_tx_if.sv
// Result-input handshake plus AXI-Stream output bundle of the
// classifier result transmitter.
interface classifier_result_tx_if
  import classifier_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = 4,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int SCORE_WIDTH = DEF_SCORE_WIDTH
);

  logic                               res_valid;
  logic                               res_ready;
  logic [7:0]                         res_class;
  logic [NUM_CLASSES*SCORE_WIDTH-1:0] res_scores;

  logic [DATA_WIDTH-1:0]              m_axis_tdata;
  logic [KEEP_WIDTH-1:0]              m_axis_tkeep;
  logic                               m_axis_tvalid;
  logic                               m_axis_tready;
  logic                               m_axis_tlast;

  modport master (
    input  res_valid,
    output res_ready,
    input  res_class,
    input  res_scores,
    output m_axis_tdata,
    output m_axis_tkeep,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tlast
  );

  modport slave (
    output res_valid,
    input  res_ready,
    output res_class,
    output res_scores,
    input  m_axis_tdata,
    input  m_axis_tkeep,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tlast
  );

endinterface

// File: rtl/classifier_result_tx_axis_out_reg.sv
// Registered AXI-Stream output stage: data/keep/last/valid change only
// when the controller issues a load (state entry or beat accept).
module axis_out_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld,
  input  logic                  nxt_vld,
  input  logic                  nxt_last,
  input  logic [DATA_WIDTH-1:0] nxt_data,
  input  logic                  tready,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic [KEEP_WIDTH-1:0] tkeep,
  output logic                  tvalid,
  output logic                  tlast,
  output logic                  acc
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [KEEP_WIDTH-1:0] keep_q, keep_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;

  always_comb begin
    data_d  = data_q;
    keep_d  = keep_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (ld) begin
      valid_d = nxt_vld;
      data_d  = nxt_vld ? nxt_data : '0;
      keep_d  = nxt_vld ? '1 : '0;
      last_d  = nxt_vld && nxt_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      keep_q  <= keep_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign tdata  = data_q;
  assign tkeep  = keep_q;
  assign tvalid = valid_q;
  assign tlast  = last_q;
  assign acc    = valid_q && tready;

endmodule

// File: rtl/classifier_result_tx.sv
// Captures one classification result and streams it as a framed packet.
// Define CLASSIFIER_TX_CRC_EN to append an XOR checksum beat.
module classifier_result_tx
  import classifier_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = 4,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int SCORE_WIDTH = DEF_SCORE_WIDTH
) (
  input logic                    clk,
  input logic                    rst,
  classifier_result_tx_if.master bus
);

  localparam int         SW       = NUM_CLASSES * SCORE_WIDTH;
  localparam logic [7:0] LAST_IDX = 8'(NUM_CLASSES - 1);
  localparam logic [7:0] NCLS     = 8'(NUM_CLASSES);
`ifdef CLASSIFIER_TX_CRC_EN
  localparam bit         CRC_ON   = 1'b1;
`else
  localparam bit         CRC_ON   = 1'b0;
`endif

  tx_state_e       state_q, state_d;
  logic [7:0]      idx_q, idx_d;
  logic [7:0]      seq_q, seq_d;
  logic [SW-1:0]   scores_q, scores_d;

  logic            take;
  logic            acc;
  logic            ld;
  logic            nxt_vld;
  logic            nxt_last;
  logic [DATA_WIDTH-1:0] nxt_data;
  logic [DATA_WIDTH-1:0] chk_data;

  function automatic logic [DATA_WIDTH-1:0] score_at(
    input logic [SW-1:0] sc,
    input logic [7:0]    i
  );
    logic signed [SCORE_WIDTH-1:0] s;
    s = sc[int'(i)*SCORE_WIDTH +: SCORE_WIDTH];
    return DATA_WIDTH'(s);
  endfunction

  // Ready is a pure state decode so it never depends on downstream tready.
  assign bus.res_ready = (state_q == IDLE) && !rst;
  assign take          = bus.res_valid && bus.res_ready;

`ifdef CLASSIFIER_TX_CRC_EN
  logic [DATA_WIDTH-1:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (take) begin
      crc_d = '0;
    end else if (acc && state_q != CHK) begin
      crc_d = crc_q ^ bus.m_axis_tdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign chk_data = crc_q ^ bus.m_axis_tdata;
`else
  assign chk_data = '0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    seq_d    = seq_q;
    scores_d = scores_q;
    ld       = 1'b0;
    nxt_vld  = 1'b0;
    nxt_last = 1'b0;
    nxt_data = '0;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          scores_d = bus.res_scores;
          ld       = 1'b1;
          nxt_vld  = 1'b1;
          nxt_data = DATA_WIDTH'(pack_hdr(seq_q, NCLS, bus.res_class));
          state_d  = HDR;
        end
      end
      HDR: begin
        if (acc) begin
          seq_d    = seq_q + 8'd1;
          idx_d    = '0;
          ld       = 1'b1;
          nxt_vld  = 1'b1;
          nxt_data = score_at(scores_q, 8'd0);
          nxt_last = !CRC_ON && (LAST_IDX == 8'd0);
          state_d  = SCORE;
        end
      end
      SCORE: begin
        if (acc) begin
          ld = 1'b1;
          if (idx_q == LAST_IDX) begin
            if (CRC_ON) begin
              nxt_vld  = 1'b1;
              nxt_data = chk_data;
              nxt_last = 1'b1;
              state_d  = CHK;
            end else begin
              state_d  = IDLE;
            end
          end else begin
            idx_d    = idx_q + 8'd1;
            nxt_vld  = 1'b1;
            nxt_data = score_at(scores_q, idx_q + 8'd1);
            nxt_last = !CRC_ON && (idx_q + 8'd1 == LAST_IDX);
          end
        end
      end
      CHK: begin
        if (acc) begin
          ld      = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      seq_q    <= '0;
      scores_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      seq_q    <= seq_d;
      scores_q <= scores_d;
    end
  end

  axis_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH)
  ) u_out (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld),
    .nxt_vld  (nxt_vld),
    .nxt_last (nxt_last),
    .nxt_data (nxt_data),
    .tready   (bus.m_axis_tready),
    .tdata    (bus.m_axis_tdata),
    .tkeep    (bus.m_axis_tkeep),
    .tvalid   (bus.m_axis_tvalid),
    .tlast    (bus.m_axis_tlast),
    .acc      (acc)
  );

endmodule

// File: tb/tb_classifier_result_tx.sv
// Randomised self-checking bench for classifier_result_tx against a
// frame-level reference model.
module tb_classifier_result_tx;

  localparam int NC = 10;
  localparam int SW = 16;
  localparam int DW = 32;
  localparam int KW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  classifier_result_tx_if #(
    .DATA_WIDTH  (DW),
    .KEEP_WIDTH  (KW),
    .NUM_CLASSES (NC),
    .SCORE_WIDTH (SW)
  ) bus ();

  classifier_result_tx #(
    .DATA_WIDTH  (DW),
    .KEEP_WIDTH  (KW),
    .NUM_CLASSES (NC),
    .SCORE_WIDTH (SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] seq_m  = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NC*SW-1:0] rnd_scores();
    logic [NC*SW-1:0] sc;
    for (int i = 0; i < NC; i++) sc[i*SW +: SW] = SW'($urandom);
    return sc;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    seq_m = 8'd0;
  endtask

  task automatic run_frame(input logic [7:0] cls, input logic [NC*SW-1:0] sc,
                           input int stall, input bit toggle,
                           input int abort_at);
    logic [31:0] exp_q[$];
    logic [31:0] x, v, pdata;
    logic signed [SW-1:0] s;
    logic plast;
    bit   pstall;
    int   beats, cyc, guard, len;

    x = {8'hC1, seq_m, 8'(NC), cls};
    exp_q.push_back(x);
    for (int i = 0; i < NC; i++) begin
      s = sc[i*SW +: SW];
      v = 32'(s);
      exp_q.push_back(v);
      x = x ^ v;
    end
`ifdef CLASSIFIER_TX_CRC_EN
    exp_q.push_back(x);
`endif
    len = exp_q.size();

    guard = 0;
    while (bus.res_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    check("rdy_idle", 32'(bus.res_ready), 32'd1);
    if (stall == 0) check("gap_wait", 32'(guard), 32'd0);

    bus.res_valid     = 1'b1;
    bus.res_class     = cls;
    bus.res_scores    = sc;
    bus.m_axis_tready = 1'b1;
    tick();
    bus.res_valid = 1'b0;

    beats  = 0;
    cyc    = 0;
    pstall = 1'b0;
    pdata  = '0;
    plast  = 1'b0;
    while (beats < len && cyc < 2000) begin
      cyc++;
      if (toggle) begin
        bus.res_class  = 8'($urandom);
        bus.res_scores = rnd_scores();
        bus.res_valid  = 1'($urandom_range(1));
      end
      check("rdy_busy", 32'(bus.res_ready), 32'd0);
      check("tvalid", 32'(bus.m_axis_tvalid), 32'd1);
      check("tkeep", 32'(bus.m_axis_tkeep), 32'hF);
      if (pstall) begin
        check("hold_data", bus.m_axis_tdata, pdata);
        check("hold_last", 32'(bus.m_axis_tlast), 32'(plast));
      end
      if (abort_at == beats) begin
        check("pre_rst_data", bus.m_axis_tdata, exp_q[beats]);
        rst = 1'b1;
        #1;
        check("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        check("rst_tlast", 32'(bus.m_axis_tlast), 32'd0);
        check("rst_rdy", 32'(bus.res_ready), 32'd0);
        bus.res_valid = 1'b0;
        tick();
        tick();
        rst   = 1'b0;
        seq_m = 8'd0;
        tick();
        return;
      end
      bus.m_axis_tready = (int'($urandom_range(99)) >= stall);
      if (bus.m_axis_tready) begin
        check("data", bus.m_axis_tdata, exp_q[beats]);
        check("last", 32'(bus.m_axis_tlast), 32'(beats == len - 1));
        beats++;
      end
      pstall = !bus.m_axis_tready;
      pdata  = bus.m_axis_tdata;
      plast  = bus.m_axis_tlast;
      if (beats < len) tick();
    end
    bus.res_valid = 1'b0;
    if (beats != len) check("frame_timeout", 32'(beats), 32'(len));
    if (stall == 0) check("frm_cyc", 32'(cyc), 32'(len));
    tick();
    check("gap_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    check("gap_rdy", 32'(bus.res_ready), 32'd1);
    seq_m = seq_m + 8'd1;
  endtask

  initial begin
    logic [NC*SW-1:0] sc;

    bus.res_valid     = 1'b0;
    bus.res_class     = '0;
    bus.res_scores    = '0;
    bus.m_axis_tready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_tvalid0", 32'(bus.m_axis_tvalid), 32'd0);
    check("rst_tlast0", 32'(bus.m_axis_tlast), 32'd0);
    check("rst_tdata0", bus.m_axis_tdata, 32'd0);
    check("rst_tkeep0", 32'(bus.m_axis_tkeep), 32'd0);
    check("rst_rdy0", 32'(bus.res_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rdy_after_rst", 32'(bus.res_ready), 32'd1);
    tick();
    seq_m = 8'd0;

    for (int i = 0; i < NC; i++) sc[i*SW +: SW] = SW'(i);
    run_frame(8'd3, sc, 0, 1'b0, -1);

    sc = rnd_scores();
    sc[SW-1:0] = 16'hFFFE;
    run_frame(8'h5A, sc, 0, 1'b0, -1);

    for (int f = 0; f < 20; f++) begin
      run_frame(8'($urandom), rnd_scores(), 50, 1'b1, -1);
    end

    run_frame(8'd7, rnd_scores(), 0, 1'b0, 6);
    run_frame(8'd9, rnd_scores(), 0, 1'b0, -1);

    do_reset();
    for (int f = 0; f < 257; f++) begin
      run_frame(8'(f), rnd_scores(), 0, 1'b0, -1);
    end

    do_reset();
    for (int i = 0; i < NC; i++) sc[i*SW +: SW] = SW'(1);
    run_frame(8'd0, sc, 0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
